// File: rtl/microaddr_types.sv
// microaddr_types: shared microaddress/command types plus the sequencer state encoding.
package microaddr_types;
  typedef logic [11:0] uaddr_t;
  typedef enum logic [2:0] {NONE, INC, JMP, CALL, RET, OPJMP} cmd_t;
  typedef enum logic [1:0] {RESET_HOLD, RUN, WAIT_MEM, HALTED} seq_state_t;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit up counter with enable and clear that sticks at 16'hFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/microseq_controller.sv
// microseq_controller: drives the microaddress counter with wait states, irq vectoring and halt/resume.
// Optional MICROSEQ_SINGLE_STEP_EN adds a step input that runs exactly one macro-instruction from HALTED.
module microseq_controller
  import microaddr_types::*;
#(
  parameter int     RESET_HOLD_CYCLES = 4,
  parameter uaddr_t IRQ_VECTOR        = 'h010
) (
  input  logic        clk,
  input  logic        reset,
  input  cmd_t        ucode_cmd,
  input  uaddr_t      ucode_load_addr,
  input  logic        ucode_mem,
  input  logic        mem_ack,
  input  logic        irq,
  input  logic        irq_en,
  input  logic        halt_req,
  input  logic        resume,
`ifdef MICROSEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  output cmd_t        uc_cmd,
  output uaddr_t      uc_load_addr,
  output logic        uc_reset,
  output logic        mem_req,
  output logic        irq_ack,
  output logic        halted,
  output logic [15:0] stall_count
);
  seq_state_t state, state_nx;
  logic [3:0] hold_cnt;
  logic issue, stop;
`ifdef MICROSEQ_SINGLE_STEP_EN
  logic step_armed;
  logic leave_halt;
  assign leave_halt = resume || step;
  always_ff @(posedge clk or posedge reset)
    if (reset) step_armed <= 1'b0;
    else if (state == HALTED && step) step_armed <= 1'b1;
    else if (issue && ucode_cmd == OPJMP) step_armed <= 1'b0;
`else
  logic step_armed;
  logic leave_halt;
  assign step_armed = 1'b0;
  assign leave_halt = resume;
`endif
  assign stop = halt_req || step_armed;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= RESET_HOLD;
      hold_cnt <= 4'(RESET_HOLD_CYCLES - 1);
    end else begin
      state <= state_nx;
      if (state == RESET_HOLD && hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
    end
  // issue marks the cycle the current microword actually reaches the counter
  always_comb begin
    state_nx     = state;
    uc_cmd       = NONE;
    uc_load_addr = '0;
    uc_reset     = 1'b0;
    mem_req      = 1'b0;
    irq_ack      = 1'b0;
    halted       = 1'b0;
    issue        = 1'b0;
    case (state)
      RESET_HOLD: begin
        uc_reset = 1'b1;
        state_nx = hold_cnt == 4'd0 ? RUN : RESET_HOLD;
      end
      RUN: begin
        mem_req  = ucode_mem;
        issue    = !(ucode_mem && !mem_ack);
        state_nx = issue ? RUN : WAIT_MEM;
      end
      WAIT_MEM: begin
        mem_req  = 1'b1;
        issue    = mem_ack;
        state_nx = mem_ack ? RUN : WAIT_MEM;
      end
      HALTED: begin
        halted   = 1'b1;
        state_nx = leave_halt ? RUN : HALTED;
      end
      default: state_nx = RESET_HOLD;
    endcase
    if (issue) begin
      if (ucode_cmd == OPJMP && stop) state_nx = HALTED;
      else if (ucode_cmd == OPJMP && irq && irq_en) begin
        uc_cmd       = JMP;
        uc_load_addr = IRQ_VECTOR;
        irq_ack      = 1'b1;
      end else begin
        uc_cmd       = ucode_cmd;
        uc_load_addr = ucode_load_addr;
      end
    end
  end
  sat_counter16 u_stall (
    .clk  (clk),
    .reset(reset),
    .en   (state == WAIT_MEM),
    .clr  (1'b0),
    .count(stall_count)
  );
endmodule

// File: tb/tb_microseq_controller.sv
// tb_microseq_controller: directed and randomized checks against a behavioural sequencer model.
module tb_microseq_controller;
  import microaddr_types::*;
  logic clk = 1'b0, reset = 1'b1;
  cmd_t ucode_cmd = NONE;
  uaddr_t ucode_load_addr = '0;
  logic ucode_mem = 1'b0, mem_ack = 1'b0, irq = 1'b0, irq_en = 1'b0, halt_req = 1'b0, resume = 1'b0;
`ifdef MICROSEQ_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  cmd_t uc_cmd;
  uaddr_t uc_load_addr;
  logic uc_reset, mem_req, irq_ack, halted;
  logic [15:0] stall_count;
  int total = 0, passed = 0;

  microseq_controller dut (
    .clk(clk), .reset(reset), .ucode_cmd(ucode_cmd), .ucode_load_addr(ucode_load_addr),
    .ucode_mem(ucode_mem), .mem_ack(mem_ack), .irq(irq), .irq_en(irq_en),
    .halt_req(halt_req), .resume(resume),
`ifdef MICROSEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .uc_cmd(uc_cmd), .uc_load_addr(uc_load_addr), .uc_reset(uc_reset), .mem_req(mem_req),
    .irq_ack(irq_ack), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: cycles of reset-hold left, whether a memory access is outstanding, halted, step armed
  int m_hold = 4, m_stalls = 0;
  bit m_wait = 0, m_halt = 0, m_armed = 0;

  always @(negedge clk) begin : compare
    cmd_t e_cmd;
    uaddr_t e_addr;
    bit e_rst, e_req, e_ack, e_halt, go, st;
    e_cmd = NONE; e_addr = '0; e_rst = 0; e_req = 0; e_ack = 0; e_halt = 0; go = 0;
`ifdef MICROSEQ_SINGLE_STEP_EN
    st = step;
`else
    st = 0;
`endif
    if (reset) begin
      m_hold = 4; m_wait = 0; m_halt = 0; m_armed = 0; m_stalls = 0;
    end
    chk("stall_count", int'(stall_count), m_stalls);
    if (reset) e_rst = 1;
    else if (m_hold > 0) begin
      e_rst = 1;
      m_hold--;
    end else if (m_halt) begin
      e_halt = 1;
      if (resume || st) m_halt = 0;
      if (st) m_armed = 1;
    end else begin
      if (m_wait) begin
        e_req = 1;
        if (m_stalls < 65535) m_stalls++;
        go = mem_ack;
        if (mem_ack) m_wait = 0;
      end else if (ucode_mem && !mem_ack) begin
        e_req = 1;
        m_wait = 1;
      end else begin
        e_req = ucode_mem;
        go = 1;
      end
      if (go) begin
        if (ucode_cmd == OPJMP && (halt_req || m_armed)) begin
          m_halt = 1;
          m_armed = 0;
        end else if (ucode_cmd == OPJMP && irq && irq_en) begin
          e_cmd = JMP; e_addr = 12'h010; e_ack = 1;
        end else begin
          if (ucode_cmd == OPJMP) m_armed = 0;
          e_cmd = ucode_cmd; e_addr = ucode_load_addr;
        end
      end
    end
    chk("uc_cmd", int'(uc_cmd), int'(e_cmd));
    if (e_cmd != NONE || reset) chk("uc_load_addr", int'(uc_load_addr), int'(e_addr));
    chk("uc_reset", int'(uc_reset), int'(e_rst));
    chk("mem_req", int'(mem_req), int'(e_req));
    chk("irq_ack", int'(irq_ack), int'(e_ack));
    chk("halted", int'(halted), int'(e_halt));
  end

  task automatic next_cyc;
    @(posedge clk); #1;
  endtask
  task automatic sample;
    @(negedge clk); #1;
  endtask

  initial begin
    int s0, incs;
    repeat (2) @(posedge clk);
    #1 reset = 0; ucode_cmd = INC; ucode_load_addr = 12'h3A5;
    for (int i = 0; i < 6; i++) begin
      sample;
      chk("hold_uc_reset", int'(uc_reset), int'(i < 4));
      chk("hold_cmd", int'(uc_cmd), i < 4 ? int'(NONE) : int'(INC));
    end
    next_cyc; ucode_mem = 1; mem_ack = 0; s0 = int'(stall_count);
    for (int i = 0; i < 3; i++) begin
      sample; chk("memwait_cmd", int'(uc_cmd), int'(NONE)); chk("memwait_req", int'(mem_req), 1);
      next_cyc;
    end
    mem_ack = 1;
    sample; chk("memack_cmd", int'(uc_cmd), int'(INC)); chk("memack_req", int'(mem_req), 1);
    next_cyc; ucode_mem = 0; mem_ack = 0;
    chk("stall_delta", int'(stall_count) - s0, 3);
    ucode_cmd = OPJMP; irq = 1; irq_en = 1;
    sample; chk("irq_cmd", int'(uc_cmd), int'(JMP)); chk("irq_addr", int'(uc_load_addr), 'h010);
    chk("irq_ack", int'(irq_ack), 1);
    next_cyc; ucode_cmd = INC;
    sample; chk("irq_ack_pulse", int'(irq_ack), 0);
    next_cyc; ucode_cmd = OPJMP; irq_en = 0;
    sample; chk("irqdis_cmd", int'(uc_cmd), int'(OPJMP)); chk("irqdis_ack", int'(irq_ack), 0);
    next_cyc; irq_en = 1; halt_req = 1;
    sample; chk("halt_cmd", int'(uc_cmd), int'(NONE)); chk("halt_ack", int'(irq_ack), 0);
    next_cyc;
    sample; chk("halted", int'(halted), 1);
    next_cyc; halt_req = 0; resume = 1;
    sample; chk("halted_resume_cycle", int'(halted), 1);
    next_cyc; resume = 0;
    sample; chk("resume_cmd", int'(uc_cmd), int'(JMP)); chk("resume_addr", int'(uc_load_addr), 'h010);
    next_cyc; irq = 0; ucode_cmd = INC; ucode_mem = 1; mem_ack = 0;
    next_cyc;
    #2 chk("wait_mem_req", int'(mem_req), 1);
    reset = 1;
    #1 chk("abort_mem_req", int'(mem_req), 0); chk("abort_halted", int'(halted), 0);
    chk("abort_uc_reset", int'(uc_reset), 1);
    next_cyc; reset = 0; ucode_mem = 0;
    repeat (5) next_cyc;
`ifdef MICROSEQ_SINGLE_STEP_EN
    ucode_cmd = OPJMP; halt_req = 1;
    next_cyc; halt_req = 0; step = 1;
    next_cyc; step = 0; ucode_cmd = INC; incs = 0;
    for (int i = 0; i < 2; i++) begin
      sample; if (uc_cmd == INC) incs++;
      next_cyc;
    end
    ucode_cmd = OPJMP;
    sample; chk("step_opjmp_cmd", int'(uc_cmd), int'(NONE));
    next_cyc; ucode_cmd = INC;
    sample; chk("step_halted", int'(halted), 1); chk("step_incs", incs, 2);
    next_cyc; resume = 1;
    next_cyc; resume = 0;
`endif
    for (int i = 0; i < 3000; i++) begin
      next_cyc;
      reset = $urandom_range(99) == 0;
      ucode_cmd = $urandom_range(3) == 0 ? OPJMP : cmd_t'($urandom_range(5));
      ucode_load_addr = uaddr_t'($urandom);
      ucode_mem = $urandom_range(9) < 3;
      mem_ack = $urandom_range(9) < 4;
      irq = $urandom_range(1);
      irq_en = $urandom_range(1);
      halt_req = $urandom_range(4) == 0;
      resume = $urandom_range(4) == 0;
`ifdef MICROSEQ_SINGLE_STEP_EN
      step = $urandom_range(9) == 0;
`endif
    end
    next_cyc; reset = 0;
    repeat (3) next_cyc;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
